sr_latch_ctrl: RTL and testbench
================================

# sr_latch_ctrl

Sequencer and arbiter that owns the S/R inputs of one `sr_latch` and shares it between a set requester and a clear requester. Every granted request becomes a fixed-width pulse on exactly one of S or R, followed by a guard interval with both inputs low. The forbidden S=R=1 combination is therefore impossible by construction. An optional readback check compares the latch's Q against the expected value after each operation.

## Interface
- `PULSE_W`, default 2: cycles S or R is held high per operation. Legal range ≥1.
- `GUARD_W`, default 1: cycles with S=R=0 after each pulse. Legal range ≥1.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst` input, 1 bit: asynchronous reset, active-high.
- `set_req` input, 1 bit: set requester, level request.
- `set_ack` output, 1 bit: one-cycle completion pulse for a set.
- `clr_req` input, 1 bit: clear requester, level request.
- `clr_ack` output, 1 bit: one-cycle completion pulse for a clear.
- `s_out` output, 1 bit: drives latch S, registered.
- `r_out` output, 1 bit: drives latch R, registered.
- `q_in` input, 1 bit: latch Q readback. Used only with `SR_LATCH_CTRL_VERIFY_EN`.
- `err_clr` input, 1 bit: clears sticky `err`.
- `busy` output, 1 bit: high in every state except IDLE.
- `err` output, 1 bit: sticky readback mismatch flag.

## Operation
- States:
  - IDLE: arbitrate.
  - PULSE: drive the selected input for PULSE_W cycles.
  - GUARD: hold S=R=0 for GUARD_W cycles.
  - DONE: 1 cycle; assert the matching ack and perform the check.
- Transitions: IDLE→PULSE on any req; PULSE→GUARD when count hits PULSE_W; GUARD→DONE when count hits GUARD_W; DONE→IDLE unconditionally.
- Arbitration in IDLE:
  - A single active req wins.
  - Both active: grant the opposite of `last_grant`, which is updated on every grant.
- The grant is latched at IDLE exit. Deasserting req after grant does not abort; the operation completes and ack still pulses.
- Requester rule: drop req in the cycle after ack. A req still high in the cycle after DONE is a new request.
- Invariant: `s_out & r_out` is never 1. `s_out`/`r_out` are high only in PULSE.
- Reset values: `s_out`=0, `r_out`=0, `set_ack`=0, `clr_ack`=0, `busy`=0, `err`=0, state=IDLE, count=0, `last_grant`=SET (a tie after reset grants CLEAR).
- Reset mid-operation: S/R drop asynchronously, no ack is issued, and the requester must re-request.
- `err_clr`: clears `err` at the next edge. Simultaneous with a new mismatch, set wins.

## Timing
- req sampled high in IDLE at edge 0 → PULSE active cycles 1..PULSE_W → GUARD cycles PULSE_W+1..PULSE_W+GUARD_W → DONE/ack at cycle PULSE_W+GUARD_W+1 → IDLE next.
- Latency from req to ack is PULSE_W+GUARD_W+1 cycles; defaults give 4.
- Back-to-back: the next grant can occur at the DONE→IDLE edge + 1, so the minimum spacing between S/R pulses is GUARD_W+2 cycles.
- The counter is width $clog2(max(PULSE_W,GUARD_W)+1), is reset to 0 on each state entry, and never wraps.

## Configuration
- `SR_LATCH_CTRL_VERIFY_EN` defined:
  - In DONE, `q_in` is compared with the expected value (1 after set, 0 after clear).
  - A mismatch sets `err` at the DONE exit edge.
- Undefined:
  - `q_in` is ignored and `err` is tied 0.
  - State sequence and latency are identical.

## Structure
- Package `sr_ctrl_pkg`: state enum (IDLE, PULSE, GUARD, DONE), grant enum (SET, CLEAR), and the parameter default constants.
- Sub-module `sr_pulse_timer`: loadable down-counter with a `done` output, shared by PULSE and GUARD.
- The bench instantiates the real `sr_latch` with `s_out`/`r_out` driving S/R and Q returning on `q_in`.

## Test plan
- Single set: `set_req`=1 at cycle 0 → `s_out`=1 cycles 1–2, `r_out`=0 throughout, `set_ack`=1 at cycle 4, Q=1.
- Simultaneous requests after reset: both req=1 → CLEAR granted first (`clr_ack` at cycle 4), then SET (`set_ack` at cycle 9). `s_out`&`r_out` is never 1.
- Held reqs: both req held high for 30 cycles → grants alternate SET/CLEAR, with pulse spacing ≥3 cycles.
- Reset mid-PULSE: assert `rst` during cycle 1 of a set → `s_out` drops in the same cycle, no `set_ack`, `busy`=0.
- VERIFY_EN fault: force `q_in`=0 during a set → `err`=1 after DONE; `err_clr` pulse → `err`=0.
- Req dropped after grant: `clr_req` high for 1 cycle → full pulse still issued and `clr_ack` at cycle 4.

Source files
------------

// File: rtl/sr_ctrl_pkg.sv
// Shared types and defaults for the S/R latch sequencer.
//   state_e     : controller FSM states (IDLE, PULSE, GUARD, DONE)
//   grant_e     : which requester owns the current operation (SET, CLEAR)
//   PULSE_W_DEF : default S/R pulse width in cycles
//   GUARD_W_DEF : default S=R=0 guard width in cycles
//   arbitrate() : grant decision for the IDLE state
package sr_ctrl_pkg;

  localparam int PULSE_W_DEF = 2;
  localparam int GUARD_W_DEF = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GUARD = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    SET   = 1'b0,
    CLEAR = 1'b1
  } grant_e;

  // A lone request wins outright; a tie goes to whichever side did not
  // win last time, so neither requester can starve the other.
  function automatic grant_e arbitrate(input logic   set_r,
                                       input logic   clr_r,
                                       input grant_e last);
    if (set_r && clr_r) return (last == SET) ? CLEAR : SET;
    else if (set_r)     return SET;
    else                return CLEAR;
  endfunction

endpackage

// File: rtl/sr_latch.sv
// Behavioural model of the target S/R latch, updated on the clock.
//   clk : clock
//   s   : set input (q becomes 1)
//   r   : reset input (q becomes 0)
//   q   : latch state; holds when s=r=0 (and on the forbidden s=r=1)
module sr_latch (
  input  logic clk,
  input  logic s,
  input  logic r,
  output logic q
);

  always_ff @(posedge clk) begin
    case ({s, r})
      2'b10:   q <= 1'b1;
      2'b01:   q <= 1'b0;
      default: q <= q;
    endcase
  end

endmodule

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter used to time both the S/R pulse and the guard gap.
//   clk, rst  : clock, asynchronous active-high reset
//   load      : load load_val on the next edge (counter then runs down)
//   load_val  : number of further cycles to count (width CW)
//   done      : counter has reached zero
module sr_pulse_timer #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  logic [CW-1:0] cnt;

  // Saturates at zero so it never wraps while the FSM sits in IDLE/DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/sr_latch_ctrl.sv
// Sequencer/arbiter that owns the S and R inputs of one S/R latch.
// Each granted request becomes a PULSE_W-cycle pulse on exactly one of
// S or R, then GUARD_W cycles with both low, then a one-cycle ack.
// S and R are only ever driven from the single latched grant, so the
// forbidden S=R=1 combination cannot occur.
//
// Optional feature: define SR_LATCH_CTRL_VERIFY_EN to compare q_in with
// the expected latch value in DONE and raise sticky err on mismatch.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   set_req, set_ack  : set requester (level request, 1-cycle ack)
//   clr_req, clr_ack  : clear requester (level request, 1-cycle ack)
//   s_out, r_out      : registered drives to latch S and R
//   q_in              : latch Q readback (VERIFY_EN only)
//   err_clr           : clears sticky err
//   busy              : controller is not IDLE
//   err               : sticky readback mismatch
module sr_latch_ctrl
  import sr_ctrl_pkg::*;
#(
  parameter int PULSE_W = PULSE_W_DEF,
  parameter int GUARD_W = GUARD_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic set_req,
  output logic set_ack,
  input  logic clr_req,
  output logic clr_ack,
  output logic s_out,
  output logic r_out,
  input  logic q_in,
  input  logic err_clr,
  output logic busy,
  output logic err
);

  localparam int MAXW = (PULSE_W > GUARD_W) ? PULSE_W : GUARD_W;
  localparam int CW   = $clog2(MAXW + 1);

  state_e        state;
  grant_e        grant;
  grant_e        last_grant;
  grant_e        req_grant;
  logic          any_req;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_done;

  assign any_req   = set_req | clr_req;
  assign req_grant = arbitrate(set_req, clr_req, last_grant);
  assign busy      = (state != IDLE);

  // The timer is loaded with N-1 on entry to PULSE/GUARD so that done
  // rises in the N-th cycle of that state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = CW'(PULSE_W - 1);
    if (state == IDLE && any_req) begin
      tmr_load = 1'b1;
    end else if (state == PULSE && tmr_done) begin
      tmr_load = 1'b1;
      tmr_val  = CW'(GUARD_W - 1);
    end
  end

  sr_pulse_timer #(
    .CW(CW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= SET;
      last_grant <= SET;
      s_out      <= 1'b0;
      r_out      <= 1'b0;
      set_ack    <= 1'b0;
      clr_ack    <= 1'b0;
    end else begin
      set_ack <= 1'b0;
      clr_ack <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state      <= PULSE;
            grant      <= req_grant;
            last_grant <= req_grant;
            s_out      <= (req_grant == SET);
            r_out      <= (req_grant == CLEAR);
          end
        end
        PULSE: begin
          if (tmr_done) begin
            state <= GUARD;
            s_out <= 1'b0;
            r_out <= 1'b0;
          end
        end
        GUARD: begin
          if (tmr_done) begin
            state   <= DONE;
            set_ack <= (grant == SET);
            clr_ack <= (grant == CLEAR);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SR_LATCH_CTRL_VERIFY_EN
  logic exp_q;
  assign exp_q = (grant == SET);

  // A new mismatch takes priority over a simultaneous err_clr.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state == DONE && q_in != exp_q) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end
`else
  logic unused_verify;
  assign unused_verify = q_in | err_clr;
  assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_sr_latch_ctrl.sv
module tb_sr_latch_ctrl;
  import sr_ctrl_pkg::*;

  localparam int P = 2;
  localparam int G = 1;
`ifdef SR_LATCH_CTRL_VERIFY_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, set_req, clr_req, err_clr, force_q;
  logic set_ack, clr_ack, s_out, r_out, busy, err;
  logic q_latch, q_in;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;

  typedef struct {
    int cyc;
    bit is_set;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign q_in = force_q ? 1'b0 : q_latch;

  sr_latch_ctrl #(.PULSE_W(P), .GUARD_W(G)) dut (
    .clk     (clk),
    .rst     (rst),
    .set_req (set_req),
    .set_ack (set_ack),
    .clr_req (clr_req),
    .clr_ack (clr_ack),
    .s_out   (s_out),
    .r_out   (r_out),
    .q_in    (q_in),
    .err_clr (err_clr),
    .busy    (busy),
    .err     (err)
  );

  sr_latch u_latch (
    .clk (clk),
    .s   (s_out),
    .r   (r_out),
    .q   (q_latch)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input int c, input bit is_set);
    exp_t e;
    e.cyc    = c;
    e.is_set = is_set;
    exp_q.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every ack, and watches the S/R
  // invariant and the gap between consecutive pulses.
  bit had_pulse = 0;
  bit prev_sr = 0;
  int low_run = 0;
  always @(negedge clk) begin
    if (rst) begin
      had_pulse = 0;
      prev_sr   = 0;
      low_run   = 0;
    end else begin
      chk("s_and_r", int'(s_out & r_out), 0);
      if ((s_out | r_out) && !prev_sr && had_pulse)
        chk("pulse_gap_ge", int'(low_run >= G + 2), 1);
      if (s_out | r_out) begin
        had_pulse = 1;
        low_run   = 0;
      end else begin
        low_run++;
      end
      prev_sr = s_out | r_out;
      if (set_ack || clr_ack) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ack_cycle", cyc, e.cyc);
          chk("ack_is_set", int'(set_ack), int'(e.is_set));
          chk("ack_is_clr", int'(clr_ack), int'(!e.is_set));
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int c;
    rst     = 1'b1;
    set_req = 1'b0;
    clr_req = 1'b0;
    err_clr = 1'b0;
    force_q = 1'b0;
    repeat (3) tick();
    chk("rst_s_out", int'(s_out), 0);
    chk("rst_r_out", int'(r_out), 0);
    chk("rst_set_ack", int'(set_ack), 0);
    chk("rst_clr_ack", int'(clr_ack), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0;
    tick();

    // Single set
    c = cyc;
    set_req = 1'b1;
    push(c + 4, 1'b1);
    tick();
    chk("set_s_c1", int'(s_out), 1);
    chk("set_r_c1", int'(r_out), 0);
    chk("set_busy_c1", int'(busy), 1);
    tick();
    chk("set_s_c2", int'(s_out), 1);
    tick();
    chk("set_s_guard", int'(s_out), 0);
    tick();
    set_req = 1'b0;
    tick();
    chk("set_q", int'(q_latch), 1);
    chk("set_busy_end", int'(busy), 0);

    // Clear request dropped right after grant
    c = cyc;
    clr_req = 1'b1;
    push(c + 4, 1'b0);
    tick();
    clr_req = 1'b0;
    chk("clr_r_c1", int'(r_out), 1);
    tick();
    chk("clr_r_c2", int'(r_out), 1);
    tick();
    chk("clr_r_guard", int'(r_out), 0);
    repeat (2) tick();
    chk("clr_q", int'(q_latch), 0);

    // Simultaneous requests after reset: CLEAR first, then SET
    do_reset();
    c = cyc;
    set_req = 1'b1;
    clr_req = 1'b1;
    push(c + 4, 1'b0);
    push(c + 9, 1'b1);
    tick();
    chk("tie_r_first", int'(r_out), 1);
    chk("tie_s_first", int'(s_out), 0);
    repeat (3) tick();
    clr_req = 1'b0;
    repeat (2) tick();
    chk("tie_s_second", int'(s_out), 1);
    repeat (3) tick();
    set_req = 1'b0;
    tick();
    chk("tie_q", int'(q_latch), 1);

    // Both requests held: grants alternate CLEAR, SET, ...
    do_reset();
    c = cyc;
    set_req = 1'b1;
    clr_req = 1'b1;
    for (int k = 0; k < 6; k++) push(c + 4 + 5 * k, (k % 2) == 1);
    repeat (30) tick();
    set_req = 1'b0;
    clr_req = 1'b0;
    repeat (8) tick();
    chk("held_busy_end", int'(busy), 0);

    // Reset in the middle of a set pulse
    c = cyc;
    set_req = 1'b1;
    tick();
    chk("midrst_s_before", int'(s_out), 1);
    rst = 1'b1;
    set_req = 1'b0;
    #1;
    chk("midrst_s_after", int'(s_out), 0);
    chk("midrst_busy", int'(busy), 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (6) tick();
    chk("midrst_idle", int'(busy), 0);

    // Readback fault during a set, then err_clr
    force_q = 1'b1;
    c = cyc;
    set_req = 1'b1;
    push(c + 4, 1'b1);
    repeat (4) tick();
    set_req = 1'b0;
    tick();
    chk("verify_err_set", int'(err), int'(EXP_ERR));
    force_q = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("verify_err_clr", int'(err), 0);

    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
